// File: rtl/sdr_cmd_checker.sv
// -----------------------------------------------------------------------------
// sdr_cmd_checker
//
// Passive SDRAM command-bus checker. Snoops the controller-to-device command
// pins, tracks IDLE/ACTIVE state per bank and flags ordering and spacing
// violations (ACT/RD/WR/PRE ordering, tRCD, tRP, tRAS). It never drives the bus.
//
// Optional feature macro: SDR_CHK_REFI_EN
//   When defined, a refresh-interval counter raises code 7 once after TREFI
//   cycles without a REF. When undefined, no counter is built.
//
// Ports:
//   sdram_clk    : SDRAM clock, all logic on its rising edge
//   sdram_reset  : synchronous, active-high reset
//   sdr_cke      : clock enable (commands decoded only when 1)
//   sdr_cs_n     : chip select (commands decoded only when 0)
//   sdr_ras_n    : RAS
//   sdr_cas_n    : CAS
//   sdr_we_n     : write enable
//   sdr_ba       : bank address
//   sdr_addr     : address, bit 10 selects precharge-all on PRE
//   bank_open    : per-bank ACTIVE flag
//   err_valid    : one-cycle pulse, one cycle after the offending command
//   err_code     : violation code (1..7), valid with err_valid
//   err_bank     : bank of the violation, valid with err_valid
//   err_count    : saturating total violation count
// -----------------------------------------------------------------------------
module sdr_cmd_checker #(
   parameter int SDR_AW  = 13,
   parameter int SDR_BAW = 2,
   parameter int TRCD    = 3,
   parameter int TRP     = 3,
   parameter int TRAS    = 6,
   parameter int TCNT_W  = 4,
   parameter int ECNT_W  = 8,
   parameter int TREFI   = 1560
) (
   input  logic                      sdram_clk,
   input  logic                      sdram_reset,
   input  logic                      sdr_cke,
   input  logic                      sdr_cs_n,
   input  logic                      sdr_ras_n,
   input  logic                      sdr_cas_n,
   input  logic                      sdr_we_n,
   input  logic [SDR_BAW-1:0]        sdr_ba,
   input  logic [SDR_AW-1:0]         sdr_addr,
   output logic [(2**SDR_BAW)-1:0]   bank_open,
   output logic                      err_valid,
   output logic [2:0]                err_code,
   output logic [SDR_BAW-1:0]        err_bank,
   output logic [ECNT_W-1:0]         err_count
);

   localparam int NB = 2**SDR_BAW;
   localparam int T_MAX = (TRAS > TRCD) ? ((TRAS > TRP) ? TRAS : TRP)
                                        : ((TRCD > TRP) ? TRCD : TRP);

   // Elaboration-time parameter sanity checks.
   generate
      if (SDR_BAW < 1 || SDR_BAW > 8) begin : g_bad_baw
         $error("sdr_cmd_checker: SDR_BAW must be in 1..8");
      end
      if (((2**TCNT_W) - 1) < T_MAX) begin : g_bad_tcnt
         $error("sdr_cmd_checker: TCNT_W too narrow for TRCD/TRP/TRAS");
      end
      if (SDR_AW < 11) begin : g_bad_aw
         $error("sdr_cmd_checker: SDR_AW must include address bit 10");
      end
   endgenerate

   localparam logic [TCNT_W-1:0] TRCD_C = TCNT_W'(TRCD);
   localparam logic [TCNT_W-1:0] TRP_C  = TCNT_W'(TRP);
   localparam logic [TCNT_W-1:0] TRAS_C = TCNT_W'(TRAS);

   typedef enum logic [2:0] {
      CMD_MRS = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
      CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
   } cmd_e;

   typedef enum logic [2:0] {
      ERR_NONE = 3'd0, ERR_ACT_OPEN = 3'd1, ERR_RW_IDLE = 3'd2, ERR_TRCD = 3'd3,
      ERR_TRP  = 3'd4, ERR_TRAS     = 3'd5, ERR_REF_OPEN = 3'd6, ERR_REFI = 3'd7
   } err_e;

   cmd_e                       cmd;
   logic                       pre_all;
   logic [NB-1:0]              tras_viol;
   logic [NB-1:0][TCNT_W-1:0]  t_act;
   logic [NB-1:0][TCNT_W-1:0]  t_pre;
   err_e                       cmd_err;
   logic [SDR_BAW-1:0]         cmd_err_bank;
   err_e                       rep_err;
   logic [SDR_BAW-1:0]         rep_bank;

   // Only bit 10 of the address matters to the checker.
   logic [SDR_AW-1:0]          addr_unused;
   assign addr_unused = sdr_addr & ~(SDR_AW'(1) << 10);

   // Command decode; deselected or clock-disabled cycles are NOPs.
   always_comb begin
      cmd     = (sdr_cke && !sdr_cs_n) ? cmd_e'({sdr_ras_n, sdr_cas_n, sdr_we_n}) : CMD_NOP;
      pre_all = (cmd == CMD_PRE) && sdr_addr[10];
   end

   // Violation detection against pre-update state; lowest code wins.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      cmd_err      = ERR_NONE;
      cmd_err_bank = sdr_ba;
      for (int b = 0; b < NB; b++) begin
         tras_viol[b] = bank_open[b] && (t_act[b] < TRAS_C);
      end
      case (cmd)
         CMD_ACT: begin
            if (bank_open[sdr_ba])              cmd_err = ERR_ACT_OPEN;
            else if (t_pre[sdr_ba] < TRP_C)     cmd_err = ERR_TRP;
         end
         CMD_RD, CMD_WR: begin
            if (!bank_open[sdr_ba])             cmd_err = ERR_RW_IDLE;
            else if (t_act[sdr_ba] < TRCD_C)    cmd_err = ERR_TRCD;
         end
         CMD_PRE: begin
            if (pre_all) begin
               // Scan downwards so the lowest violating bank is reported.
               for (int b = NB - 1; b >= 0; b--) begin
                  if (tras_viol[b]) begin
                     cmd_err      = ERR_TRAS;
                     cmd_err_bank = SDR_BAW'(b);
                  end
               end
            end else if (tras_viol[sdr_ba]) begin
               cmd_err = ERR_TRAS;
            end
         end
         CMD_REF, CMD_MRS: begin
            if (|bank_open) begin
               cmd_err      = ERR_REF_OPEN;
               cmd_err_bank = '0;
            end
         end
         default: ;
      endcase
      if (cmd_err == ERR_NONE) cmd_err_bank = '0;
   end

`ifdef SDR_CHK_REFI_EN
   localparam int RW = $clog2(TREFI + 1);
   localparam logic [RW-1:0] TREFI_C = RW'(TREFI);

   logic [RW-1:0] refi_cnt;
   logic          refi_fired;   // code 7 already raised since last REF
   logic          refi_pend;    // code 7 deferred by a command error
   logic          refi_due;

   always_comb begin
      refi_due = (refi_cnt >= TREFI_C) && !refi_fired;
      rep_err  = cmd_err;
      rep_bank = cmd_err_bank;
      if (cmd_err == ERR_NONE && (refi_pend || refi_due)) begin
         rep_err  = ERR_REFI;
         rep_bank = '0;
      end
   end

   always_ff @(posedge sdram_clk) begin
      if (sdram_reset) begin
         refi_cnt   <= '0;
         refi_fired <= 1'b0;
         refi_pend  <= 1'b0;
      end else begin
         if (cmd == CMD_REF)        refi_cnt <= '0;
         else if (refi_cnt != '1)   refi_cnt <= refi_cnt + 1'b1;
         if (cmd == CMD_REF)        refi_fired <= 1'b0;
         else if (refi_due)         refi_fired <= 1'b1;
         refi_pend <= (refi_pend || refi_due) && (cmd_err != ERR_NONE);
      end
   end
`else
   localparam int TREFI_UNUSED = TREFI;

   always_comb begin
      rep_err  = cmd_err;
      rep_bank = cmd_err_bank;
   end
`endif

   // Bank state, timers and registered error reporting.
   always_ff @(posedge sdram_clk) begin
      if (sdram_reset) begin
         bank_open <= '0;
         // NOTE: timer arrays are reset (to saturated) because their value decides the legality of the first command.
         t_act     <= '1;
         t_pre     <= '1;
         err_valid <= 1'b0;
         err_code  <= 3'd0;
         err_bank  <= '0;
         err_count <= '0;
      end else begin
         for (int b = 0; b < NB; b++) begin
            // NOTE: non-blocking assignments here, so a later load in the same block overrides the increment.
            if (t_act[b] != '1) t_act[b] <= t_act[b] + 1'b1;
            if (t_pre[b] != '1) t_pre[b] <= t_pre[b] + 1'b1;
            if (cmd == CMD_ACT && sdr_ba == SDR_BAW'(b)) begin
               bank_open[b] <= 1'b1;
               t_act[b]     <= TCNT_W'(1);
            end
            if (cmd == CMD_PRE && (pre_all || sdr_ba == SDR_BAW'(b))) begin
               bank_open[b] <= 1'b0;
               t_pre[b]     <= TCNT_W'(1);
            end
         end
         err_valid <= (rep_err != ERR_NONE);
         err_code  <= rep_err;
         err_bank  <= rep_bank;
         if (rep_err != ERR_NONE && err_count != '1) err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_sdr_cmd_checker.sv
// -----------------------------------------------------------------------------
// tb_sdr_cmd_checker
//
// Directed bench for sdr_cmd_checker with hand-computed expectations.
// Commands are driven 1 ns after a rising edge and outputs are sampled 1 ns
// after the edge that captured the command, so each sample shows the
// registered response to the command just issued.
// -----------------------------------------------------------------------------
module tb_sdr_cmd_checker;

   localparam logic [2:0] C_MRS = 3'b000;
   localparam logic [2:0] C_REF = 3'b001;
   localparam logic [2:0] C_PRE = 3'b010;
   localparam logic [2:0] C_ACT = 3'b011;
   localparam logic [2:0] C_WR  = 3'b100;
   localparam logic [2:0] C_RD  = 3'b101;
   localparam logic [2:0] C_NOP = 3'b111;

   logic        clk = 1'b0;
   logic        rst;
   logic        cke, cs_n, ras_n, cas_n, we_n;
   logic [1:0]  ba;
   logic [12:0] addr;
   logic [3:0]  bank_open;
   logic        err_valid;
   logic [2:0]  err_code;
   logic [1:0]  err_bank;
   logic [7:0]  err_count;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   sdr_cmd_checker #(
      .SDR_AW(13), .SDR_BAW(2), .TRCD(3), .TRP(3), .TRAS(6),
      .TCNT_W(4), .ECNT_W(8), .TREFI(4000)
   ) dut (
      .sdram_clk(clk), .sdram_reset(rst), .sdr_cke(cke), .sdr_cs_n(cs_n),
      .sdr_ras_n(ras_n), .sdr_cas_n(cas_n), .sdr_we_n(we_n),
      .sdr_ba(ba), .sdr_addr(addr), .bank_open(bank_open),
      .err_valid(err_valid), .err_code(err_code), .err_bank(err_bank),
      .err_count(err_count)
   );

`ifdef SDR_CHK_REFI_EN
   logic [3:0] r_bank_open;
   logic       r_err_valid;
   logic [2:0] r_err_code;
   logic [1:0] r_err_bank;
   logic [7:0] r_err_count;

   sdr_cmd_checker #(
      .SDR_AW(13), .SDR_BAW(2), .TRCD(3), .TRP(3), .TRAS(6),
      .TCNT_W(4), .ECNT_W(8), .TREFI(50)
   ) dut_refi (
      .sdram_clk(clk), .sdram_reset(rst), .sdr_cke(cke), .sdr_cs_n(cs_n),
      .sdr_ras_n(ras_n), .sdr_cas_n(cas_n), .sdr_we_n(we_n),
      .sdr_ba(ba), .sdr_addr(addr), .bank_open(r_bank_open),
      .err_valid(r_err_valid), .err_code(r_err_code), .err_bank(r_err_bank),
      .err_count(r_err_count)
   );
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_err(input string tag, input logic v, input logic [2:0] code,
                            input logic [1:0] bank, input logic [7:0] cnt);
      check({tag, "_valid"}, 32'(err_valid), 32'(v));
      if (v) begin
         check({tag, "_code"}, 32'(err_code), 32'(code));
         check({tag, "_bank"}, 32'(err_bank), 32'(bank));
      end
      check({tag, "_count"}, 32'(err_count), 32'(cnt));
   endtask

   task automatic step_raw(input logic k, input logic cs, input logic [2:0] c,
                           input logic [1:0] b, input logic a10);
      cke  = k;
      cs_n = cs;
      {ras_n, cas_n, we_n} = c;
      ba   = b;
      addr = '0;
      addr[10] = a10;
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic [2:0] c, input logic [1:0] b, input logic a10);
      step_raw(1'b1, 1'b0, c, b, a10);
   endtask

   task automatic nop(input int n);
      repeat (n) step(C_NOP, 2'd0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      cke = 1'b0; cs_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
      ba = '0; addr = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_bank_open", 32'(bank_open), 32'h0);
      check("rst_err_valid", 32'(err_valid), 32'h0);
      check("rst_err_code",  32'(err_code),  32'h0);
      check("rst_err_bank",  32'(err_bank),  32'h0);
      check("rst_err_count", 32'(err_count), 32'h0);
      rst = 1'b0;

      // Idle bus.
      for (int i = 0; i < 20; i++) begin
         nop(1);
         check("idle_err_valid", 32'(err_valid), 32'h0);
      end
      check("idle_bank_open", 32'(bank_open), 32'h0);
      check("idle_err_count", 32'(err_count), 32'h0);

      // ACT pattern with cs_n high or cke low must be ignored.
      step_raw(1'b1, 1'b1, C_ACT, 2'd1, 1'b0);
      check("cs_gate_bank_open", 32'(bank_open), 32'h0);
      step_raw(1'b0, 1'b0, C_ACT, 2'd1, 1'b0);
      check("cke_gate_bank_open", 32'(bank_open), 32'h0);

      // tRCD exactly met.
      step(C_ACT, 2'd1, 1'b0);
      check("act1_bank_open", 32'(bank_open), 32'h2);
      check_err("act1", 1'b0, 3'd0, 2'd0, 8'd0);
      nop(2);
      step(C_RD, 2'd1, 1'b0);
      check_err("rd_trcd_ok", 1'b0, 3'd0, 2'd0, 8'd0);
      nop(4);
      step(C_PRE, 2'd1, 1'b0);
      check_err("pre1_ok", 1'b0, 3'd0, 2'd0, 8'd0);
      check("pre1_bank_open", 32'(bank_open), 32'h0);
      nop(2);
      step(C_ACT, 2'd1, 1'b0);
      check_err("act1_trp_ok", 1'b0, 3'd0, 2'd0, 8'd0);
      // tRCD violated by one cycle.
      nop(1);
      step(C_RD, 2'd1, 1'b0);
      check_err("rd_trcd_bad", 1'b1, 3'd3, 2'd1, 8'd1);
      nop(1);
      check_err("pulse_end", 1'b0, 3'd0, 2'd0, 8'd1);
      nop(5);
      step(C_PRE, 2'd1, 1'b0);
      check_err("pre1b_ok", 1'b0, 3'd0, 2'd0, 8'd1);

      // tRAS then tRP violations on bank 2.
      step(C_ACT, 2'd2, 1'b0);
      nop(3);
      step(C_PRE, 2'd2, 1'b0);
      check_err("pre2_tras", 1'b1, 3'd5, 2'd2, 8'd2);
      check("pre2_bank_open", 32'(bank_open), 32'h0);
      nop(1);
      check("pre2_pulse_end", 32'(err_valid), 32'h0);
      step(C_ACT, 2'd2, 1'b0);
      check_err("act2_trp", 1'b1, 3'd4, 2'd2, 8'd3);
      check("act2_bank_open", 32'(bank_open), 32'h4);

      // Double ACT and WR to an idle bank.
      step(C_ACT, 2'd0, 1'b0);
      check_err("act0_ok", 1'b0, 3'd0, 2'd0, 8'd3);
      check("act0_bank_open", 32'(bank_open), 32'h5);
      step(C_ACT, 2'd0, 1'b0);
      check_err("act0_twice", 1'b1, 3'd1, 2'd0, 8'd4);
      step(C_WR, 2'd3, 1'b0);
      check_err("wr3_idle", 1'b1, 3'd2, 2'd3, 8'd5);

      // PRE-all, then ACT b0 + b3, PRE-all, REF.
      nop(6);
      step(C_PRE, 2'd0, 1'b1);
      check_err("preall_a", 1'b0, 3'd0, 2'd0, 8'd5);
      check("preall_a_bank_open", 32'(bank_open), 32'h0);
      nop(3);
      step(C_ACT, 2'd0, 1'b0);
      step(C_ACT, 2'd3, 1'b0);
      check("act03_bank_open", 32'(bank_open), 32'h9);
      check_err("act03", 1'b0, 3'd0, 2'd0, 8'd5);
      nop(6);
      step(C_PRE, 2'd0, 1'b1);
      check_err("preall_b", 1'b0, 3'd0, 2'd0, 8'd5);
      check("preall_b_bank_open", 32'(bank_open), 32'h0);
      step(C_REF, 2'd0, 1'b0);
      check_err("ref_closed", 1'b0, 3'd0, 2'd0, 8'd5);
      nop(1);

      // PRE-all tRAS violation on banks 1 and 2 reports bank 1.
      step(C_ACT, 2'd1, 1'b0);
      step(C_ACT, 2'd2, 1'b0);
      check_err("act12", 1'b0, 3'd0, 2'd0, 8'd5);
      step(C_PRE, 2'd2, 1'b1);
      check_err("preall_tras", 1'b1, 3'd5, 2'd1, 8'd6);
      check("preall_tras_bank_open", 32'(bank_open), 32'h0);

      // PRE to an idle bank still loads its tRP timer.
      step(C_PRE, 2'd3, 1'b0);
      check_err("pre3_idle", 1'b0, 3'd0, 2'd0, 8'd6);
      step(C_ACT, 2'd3, 1'b0);
      check_err("act3_trp", 1'b1, 3'd4, 2'd3, 8'd7);
      check("act3_bank_open", 32'(bank_open), 32'h8);

      // REF / MRS with a bank open.
      step(C_REF, 2'd2, 1'b0);
      check_err("ref_open", 1'b1, 3'd6, 2'd0, 8'd8);
      step(C_MRS, 2'd1, 1'b0);
      check_err("mrs_open", 1'b1, 3'd6, 2'd0, 8'd9);
      check("mrs_bank_open", 32'(bank_open), 32'h8);

      // Priority: ACT to an open bank inside tRP reports code 1.
      step(C_PRE, 2'd3, 1'b0);
      check_err("pre3_tras", 1'b1, 3'd5, 2'd3, 8'd10);
      step(C_ACT, 2'd3, 1'b0);
      check_err("act3_trp_b", 1'b1, 3'd4, 2'd3, 8'd11);
      step(C_ACT, 2'd3, 1'b0);
      check_err("act3_prio", 1'b1, 3'd1, 2'd3, 8'd12);

      // Counter saturation.
      repeat (300) step(C_ACT, 2'd3, 1'b0);
      check_err("sat", 1'b1, 3'd1, 2'd3, 8'd255);
      nop(1);
      check_err("sat_hold", 1'b0, 3'd0, 2'd0, 8'd255);

      // Reset mid-operation, then an immediate ACT is legal.
      rst = 1'b1;
      step(C_ACT, 2'd0, 1'b0);
      rst = 1'b0;
      check("mid_rst_bank_open", 32'(bank_open), 32'h0);
      check_err("mid_rst", 1'b0, 3'd0, 2'd0, 8'd0);
      step(C_ACT, 2'd0, 1'b0);
      check_err("post_rst_act", 1'b0, 3'd0, 2'd0, 8'd0);
      check("post_rst_bank_open", 32'(bank_open), 32'h1);
      step(C_RD, 2'd0, 1'b0);
      check_err("post_rst_rd", 1'b1, 3'd3, 2'd0, 8'd1);

`ifdef SDR_CHK_REFI_EN
      begin
         int pulses;
         rst = 1'b1;
         nop(1);
         rst = 1'b0;
         pulses = 0;
         for (int i = 0; i < 60; i++) begin
            nop(1);
            if (r_err_valid && r_err_code == 3'd7 && r_err_bank == 2'd0) pulses++;
         end
         check("refi_first", 32'(pulses), 32'd1);
         step(C_REF, 2'd0, 1'b0);
         pulses = 0;
         for (int i = 0; i < 60; i++) begin
            nop(1);
            if (r_err_valid && r_err_code == 3'd7 && r_err_bank == 2'd0) pulses++;
         end
         check("refi_second", 32'(pulses), 32'd1);
         check("refi_count", 32'(r_err_count), 32'd2);
         check("refi_bank_open", 32'(r_bank_open), 32'h0);
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
